// File: rtl/sorter_pkg.sv
// Shared constants and types for the 8-input descending-order sorter and its
// word loader.
package sorter_pkg;

  localparam int WORD_W = 16;
  localparam int N_IN   = 8;

  typedef enum logic {
    LD_FILL = 1'b0,
    LD_FULL = 1'b1
  } ld_state_e;

  typedef logic [$clog2(N_IN)-1:0] slot_idx_t;

endpackage

// File: rtl/slot_reg.sv
// One bank slot of the word loader: a WIDTH-bit register with write-enable
// and a synchronous clear that takes priority over the write.
module slot_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d, data_q;

  // NOTE: every path assigns data_d after the hold default, so no latch is inferred.
  always_comb begin
    data_d = data_q;
    if (clr)        data_d = '0;
    else if (wr_en) data_d = d;
  end

  // NOTE: the bank lives in flops, not RAM, so it can and does take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/word_demux_loader.sv
// Serial-to-parallel loader: steers one word per handshake into slot 0..DEPTH-1
// and presents the full bank with valid/ready. Define LOADER_CLEAR_EN to clear
// the bank on unload and on abort.
module word_demux_loader
  import sorter_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int DEPTH = N_IN,
  localparam int CW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH*DEPTH-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          slot_idx
);

  ld_state_e     state_d, state_q;
  logic [CW-1:0] slot_d, slot_q;
  logic          in_ready_d, in_ready_q;
  logic          out_valid_d, out_valid_q;
  logic          accept, unload, bank_clr;

  // abort wins over a coincident word, so the word never reaches the bank
  assign accept = in_valid && in_ready_q && !abort;
  assign unload = (state_q == LD_FULL) && out_ready;

`ifdef LOADER_CLEAR_EN
  assign bank_clr = abort || unload;
`else
  assign bank_clr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (abort) begin
      state_d = LD_FILL;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        LD_FILL: begin
          if (accept) begin
            if (slot_q == CW'(DEPTH - 1)) begin
              slot_d  = '0;
              state_d = LD_FULL;
            end else begin
              slot_d = slot_q + CW'(1);
            end
          end
        end
        LD_FULL: begin
          if (unload) state_d = LD_FILL;
        end
        default: state_d = LD_FILL;
      endcase
    end
    in_ready_d  = (state_d == LD_FILL);
    out_valid_d = (state_d == LD_FULL);
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state math stays in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_FILL;
      slot_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    slot_reg #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .wr_en (accept && (slot_q == CW'(k))),
      .clr   (bank_clr),
      .d     (in_data),
      .q     (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign slot_idx  = slot_q;

endmodule

// File: tb/tb_word_demux_loader.sv
// Self-checking bench for word_demux_loader: directed scenarios plus random
// traffic, checked against a queue-based frame model.
module tb_word_demux_loader;

  localparam int W = 16;
  localparam int D = 8;

  logic           clk, rst, abort, in_valid, out_ready;
  logic [W-1:0]   in_data;
  logic           in_ready, out_valid;
  logic [W*D-1:0] out_data;
  logic [2:0]     slot_idx;

  word_demux_loader dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot_idx  (slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: words collected for the current frame, plus what the bank shows.
  logic [W-1:0] frame_q[$];
  logic [W-1:0] m_bank[D];
  bit           m_full;

  function automatic void model_reset();
    frame_q.delete();
    m_full = 0;
    for (int k = 0; k < D; k++) m_bank[k] = '0;
  endfunction

  function automatic void model_clear_opt();
`ifdef LOADER_CLEAR_EN
    for (int k = 0; k < D; k++) m_bank[k] = '0;
`endif
  endfunction

  function automatic void model_step(bit v, logic [W-1:0] d, bit ordy, bit ab);
    if (ab) begin
      frame_q.delete();
      m_full = 0;
      model_clear_opt();
    end else if (m_full) begin
      if (ordy) begin
        m_full = 0;
        model_clear_opt();
      end
    end else if (v) begin
      m_bank[frame_q.size()] = d;
      frame_q.push_back(d);
      if (frame_q.size() == D) begin
        m_full = 1;
        frame_q.delete();
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [W*D-1:0] exp_bank;
    for (int k = 0; k < D; k++) exp_bank[k*W +: W] = m_bank[k];
    check({tag, ".in_ready"},  128'(in_ready),  128'(!m_full));
    check({tag, ".out_valid"}, 128'(out_valid), 128'(m_full));
    check({tag, ".slot_idx"},  128'(slot_idx),  128'(frame_q.size()));
    check({tag, ".out_data"},  128'(out_data),  128'(exp_bank));
  endtask

  // Called at a negedge: drive, let one rising edge happen, compare at the next negedge.
  task automatic cycle(input string tag, input bit v, input logic [W-1:0] d,
                       input bit ordy, input bit ab);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    abort     = ab;
    @(posedge clk);
    model_step(v, d, ordy, ab);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    #3 compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back frame 1..8, then hold FULL for 20 cycles
    for (int i = 1; i <= D; i++) cycle("fill", 1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("hold", 1'b0, W'($urandom), 1'b0, 1'b0);

    // Unload pulse, then a new frame A000..A007
    cycle("unload", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) cycle("refill", 1'b1, W'(16'hA000 + i), 1'b0, 1'b0);
    cycle("unload2", 1'b0, '0, 1'b1, 1'b0);

    // Gapped input with data changing during gaps
    for (int i = 0; i < 2 * D; i++) cycle("gap", (i % 2) == 0, W'($urandom), 1'b0, 1'b0);
    cycle("gap_full", 1'b0, '0, 1'b0, 1'b0);
    cycle("unload3", 1'b0, '0, 1'b1, 1'b0);

    // Abort coinciding with the 6th word, then a clean frame
    for (int i = 0; i < 5; i++) cycle("pre_abort", 1'b1, W'($urandom), 1'b0, 1'b0);
    cycle("abort", 1'b1, 16'hDEAD, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) cycle("post_abort", 1'b1, W'(16'h5000 + i), 1'b0, 1'b0);

    // FULL ignores input words
    for (int i = 0; i < 10; i++) cycle("full_ignore", 1'b1, 16'hFFFF, 1'b0, 1'b0);
    // abort together with out_ready in FULL
    cycle("abort_unload", 1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset mid-frame, away from any clock edge
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, W'($urandom), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle("rand", ($urandom % 4) != 0, W'($urandom), ($urandom % 3) == 0,
            ($urandom % 40) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
